// File: rtl/hni_txdat_pkg.sv
// hni_txdat_pkg: state encodings, credit constants and the credit-return flit for the HNI TX data channel.
`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 128
`endif
package hni_txdat_pkg;
    typedef enum logic [1:0] {
        HNI_TXDAT_STOP   = 2'd0,
        HNI_TXDAT_RUN    = 2'd1,
        HNI_TXDAT_RETURN = 2'd2
    } hni_txdat_state_e;
    localparam int         DAT_FLIT_WIDTH            = `CHIE_DAT_FLIT_WIDTH;
    localparam logic [3:0] HNI_LL_CRD_INCDEC_ONE     = 4'd1;
    localparam logic [3:0] HNI_LL_MAX_CRD            = 4'd15;
    localparam logic [3:0] HNI_DAT_OPCODE_LCRDRETURN = 4'h0;
    localparam int         HNI_DAT_OPCODE_LSB        = 0;
    function automatic logic [DAT_FLIT_WIDTH-1:0] lcrd_return_flit();
        logic [DAT_FLIT_WIDTH-1:0] f;
        f = '0;
        f[HNI_DAT_OPCODE_LSB +: 4] = HNI_DAT_OPCODE_LCRDRETURN;
        return f;
    endfunction
endpackage

// File: rtl/hni_ll_crd_cnt.sv
// hni_ll_crd_cnt: saturating link-credit counter shared by the TX channels.
// HNI_TXDAT_CRD_OVF_CHK_EN enables the sticky overflow flag; otherwise ovf is tied low.
module hni_ll_crd_cnt
    import hni_txdat_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(HNI_LL_MAX_CRD);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(HNI_LL_CRD_INCDEC_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && !dec && cnt != MAX)
            cnt <= cnt + ONE;
        else if (dec && !inc)
            cnt <= cnt - ONE;
    end

`ifdef HNI_TXDAT_CRD_OVF_CHK_EN
    logic sat_hit;
    assign sat_hit = inc && !dec && cnt == MAX;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (sat_hit)
            ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: rtl/hni_txdat.sv
// hni_txdat: HNI TX data channel -- credit-gated flit issue plus credit return on link shutdown.
// Credit overflow flag is present only with HNI_TXDAT_CRD_OVF_CHK_EN.
module hni_txdat
    import hni_txdat_pkg::*;
#(
    parameter int HNI_LL_DAT_CRD_CNT_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            txdat_link_run,
    input  logic                            txdat_valid_s0,
    input  logic [`CHIE_DAT_FLIT_WIDTH-1:0] txdatflit_s0,
    output logic                            txdat_ready_s0,
    input  logic                            txdatlcrdv,
    output logic                            txdatflitpend,
    output logic                            txdatflitv,
    output logic [`CHIE_DAT_FLIT_WIDTH-1:0] txdatflit,
    output logic                            txdat_ret_done,
    output logic                            txdat_crd_err
);
    hni_txdat_state_e state, state_nxt;
    logic [HNI_LL_DAT_CRD_CNT_WIDTH-1:0] crd_cnt;
    logic crd_avail, accept, ret_issue, issue;

    assign crd_avail      = crd_cnt != '0;
    assign txdat_ready_s0 = state == HNI_TXDAT_RUN && crd_avail;
    assign accept         = txdat_valid_s0 && txdat_ready_s0;
    assign ret_issue      = state == HNI_TXDAT_RETURN && crd_avail;
    assign issue          = accept || ret_issue;

    hni_ll_crd_cnt #(.WIDTH(HNI_LL_DAT_CRD_CNT_WIDTH)) u_crd_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (txdatlcrdv),
        .dec  (issue),
        .cnt  (crd_cnt),
        .ovf  (txdat_crd_err)
    );

    // RETURN holds while any credit remains or is still arriving.
    always_comb begin
        state_nxt = state == HNI_TXDAT_STOP ? (txdat_link_run ? HNI_TXDAT_RUN : HNI_TXDAT_STOP)
                  : state == HNI_TXDAT_RUN  ? (txdat_link_run ? HNI_TXDAT_RUN : HNI_TXDAT_RETURN)
                  : (!crd_avail && !txdatlcrdv) ? HNI_TXDAT_STOP : HNI_TXDAT_RETURN;
    end

    // pend follows the next state so it rises with RUN, ahead of any flitv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HNI_TXDAT_STOP;
            txdatflitpend  <= 1'b0;
            txdatflitv     <= 1'b0;
            txdatflit      <= '0;
            txdat_ret_done <= 1'b0;
        end else begin
            state          <= state_nxt;
            txdatflitpend  <= state_nxt != HNI_TXDAT_STOP;
            txdatflitv     <= issue;
            txdatflit      <= accept ? txdatflit_s0 : ret_issue ? lcrd_return_flit() : '0;
            txdat_ret_done <= state == HNI_TXDAT_RETURN && state_nxt == HNI_TXDAT_STOP;
        end
    end
endmodule
